key_event_scheduler: RTL and testbench



---
 rtl/key_evt_pkg.sv | 27 ++
 rtl/evt_fifo.sv | 57 +++++
 rtl/key_event_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_key_event_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event scheduler: event codes, scheduler states, index helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package key_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sched_state_e;

  // Width of a key index; a single key still gets a 1-bit field.
  function automatic int key_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (a + b) mod n for operands already below n; avoids a general divider.
  function automatic int wrap_inc(input int a, input int b, input int n);
    int sum;
    sum = a + b;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Generic synchronous first-word-fall-through FIFO with full/empty flags.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes are ignored while full, pops are ignored while empty.
module evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o    = (wr_q == rd_q);
  assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer registers; contents are discarded by clearing them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; entries need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Multi-key debounce with press/long/release events arbitrated round-robin into an event FIFO.
// Latency: 2 sync cycles + up to STABLE_TICKS ticks to commit; event valid 2 cycles after the commit tick.
// Backpressure: evt_valid/evt_ready; a full FIFO stalls the scheduler and holds pending flags.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int    NUM_KEYS     = 4,
  parameter int    TICK_DIV     = 50000,
  parameter int    STABLE_TICKS = 4,
  parameter int    LONG_TICKS   = 100,
  parameter int    FIFO_DEPTH   = 4,
  parameter string POLARITY     = "HIGH"
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_KEYS-1:0]        key_in,
  output logic [NUM_KEYS-1:0]        key_state,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [key_w(NUM_KEYS)-1:0] evt_key,
  output logic [1:0]                 evt_type,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int   KW       = key_w(NUM_KEYS);
  localparam int   EW       = KW + 2;
  localparam int   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic ACT_HIGH = (POLARITY == "HIGH");

  // Input conditioning
  logic [NUM_KEYS-1:0] sync1_q, sync2_q, s;

  // Prescaler
  logic [PW-1:0] div_q, div_d;
  logic          tick;

  // Debounce and long-press state
  logic [NUM_KEYS-1:0] state_q, state_d;
  logic [3:0]          cnt_q  [NUM_KEYS];
  logic [3:0]          cnt_d  [NUM_KEYS];
  logic [9:0]          lcnt_q [NUM_KEYS];
  logic [9:0]          lcnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] set_p, set_l, set_r;

  // Pending flags
  logic [NUM_KEYS-1:0] pend_p_q, pend_l_q, pend_r_q;
  logic [NUM_KEYS-1:0] pend_p_d, pend_l_d, pend_r_d;
  logic [NUM_KEYS-1:0] clr_p, clr_l, clr_r;
  logic [NUM_KEYS-1:0] key_any;
  logic                any_pend;
  logic                collide;
  logic                overflow_q, overflow_d;

  // Scheduler
  sched_state_e  st_q, st_d;
  logic [KW-1:0] rr_q, rr_d;
  logic [KW-1:0] sel_key, cand;
  logic          found;
  logic          push;
  logic [1:0]    push_type;

  // FIFO side
  logic          fifo_full, fifo_empty, pop;
  logic [EW-1:0] head_dat;

  // Two-flop synchronizer, reset to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= {NUM_KEYS{~ACT_HIGH}};
      sync2_q <= {NUM_KEYS{~ACT_HIGH}};
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign s    = ACT_HIGH ? sync2_q : ~sync2_q;
  assign tick = (div_q == PW'(TICK_DIV - 1));

  // Shared sample-tick prescaler.
  always_comb begin
    div_d = tick ? '0 : div_q + PW'(1);
  end

  // Per-key debounce and long-press counting; emits one-cycle set requests.
  always_comb begin
    state_d = state_q;
    set_p   = '0;
    set_l   = '0;
    set_r   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k]  = cnt_q[k];
      lcnt_d[k] = lcnt_q[k];
      if (tick) begin
        if (s[k] != state_q[k]) begin
          if (cnt_q[k] + 4'd1 == 4'(STABLE_TICKS)) begin
            state_d[k] = ~state_q[k];
            cnt_d[k]   = '0;
            set_p[k]   = s[k];
            set_r[k]   = ~s[k];
          end else begin
            cnt_d[k] = cnt_q[k] + 4'd1;
          end
        end else begin
          cnt_d[k] = '0;
        end
      end
      if (!state_q[k]) begin
        lcnt_d[k] = '0;
      end else if (tick && (lcnt_q[k] != 10'(LONG_TICKS))) begin
        lcnt_d[k] = lcnt_q[k] + 10'd1;
        set_l[k]  = (lcnt_q[k] + 10'd1 == 10'(LONG_TICKS));
      end
    end
  end

  // Round-robin key choice starting at rr_q.
  always_comb begin
    sel_key = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cand = KW'(wrap_inc(int'(rr_q), i, NUM_KEYS));
      if (!found && key_any[cand]) begin
        found   = 1'b1;
        sel_key = cand;
      end
    end
  end

  assign key_any  = pend_p_q | pend_l_q | pend_r_q;
  assign any_pend = |key_any;

  // Scheduler FSM: IDLE wakes on any pending flag and pushes in the same cycle.
  always_comb begin
    st_d = st_q;
    push = 1'b0;
    case (st_q)
      IDLE: begin
        if (any_pend) begin
          st_d = SCAN;
          push = !fifo_full;
        end
      end
      SCAN: begin
        if (!any_pend) st_d = IDLE;
        else           push = !fifo_full;
      end
      default: st_d = IDLE;
    endcase
  end

  // Within a key serve press, then long, then release to keep chronology.
  always_comb begin
    clr_p     = '0;
    clr_l     = '0;
    clr_r     = '0;
    push_type = EVT_PRESS;
    rr_d      = rr_q;
    if (push) begin
      rr_d = KW'(wrap_inc(int'(sel_key), 1, NUM_KEYS));
      if (pend_p_q[sel_key]) begin
        clr_p[sel_key] = 1'b1;
        push_type      = EVT_PRESS;
      end else if (pend_l_q[sel_key]) begin
        clr_l[sel_key] = 1'b1;
        push_type      = EVT_LONG;
      end else begin
        clr_r[sel_key] = 1'b1;
        push_type      = EVT_RELEASE;
      end
    end
  end

  // Flag update; a set onto a flag that is still held (and not being served) is dropped.
  always_comb begin
    pend_p_d   = (pend_p_q & ~clr_p) | set_p;
    pend_l_d   = (pend_l_q & ~clr_l) | set_l;
    pend_r_d   = (pend_r_q & ~clr_r) | set_r;
    collide    = |((set_p & pend_p_q & ~clr_p) |
                   (set_l & pend_l_q & ~clr_l) |
                   (set_r & pend_r_q & ~clr_r));
    overflow_d = collide | (overflow_q & ~clr_overflow);
  end

  // State registers for prescaler, debounce, flags and scheduler.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      state_q    <= '0;
      pend_p_q   <= '0;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
      overflow_q <= 1'b0;
      st_q       <= IDLE;
      rr_q       <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k]  <= '0;
        lcnt_q[k] <= '0;
      end
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      pend_p_q   <= pend_p_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      overflow_q <= overflow_d;
      st_q       <= st_d;
      rr_q       <= rr_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_q[k]  <= cnt_d[k];
        lcnt_q[k] <= lcnt_d[k];
      end
    end
  end

  evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (push),
    .push_dat_i ({sel_key, push_type}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign pop       = evt_valid & evt_ready;
  assign evt_valid = ~fifo_empty;
  assign evt_key   = head_dat[EW-1:2];
  assign evt_type  = head_dat[1:0];
  assign key_state = state_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler: table-driven press/bounce steps plus hand-written sequences.
// Latency: checks the exact commit/event timing for a key held through reset.
// Backpressure: holds evt_ready low to exercise FIFO-full stalls and flag collisions.
module tb_key_event_scheduler;

  localparam int TD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       overflow;
  logic       clr_overflow;

  int checks = 0;
  int errors = 0;

  key_event_scheduler #(
    .NUM_KEYS     (4),
    .TICK_DIV     (TD),
    .STABLE_TICKS (4),
    .LONG_TICKS   (10),
    .FIFO_DEPTH   (4),
    .POLARITY     ("HIGH")
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_in       (key_in),
    .key_state    (key_state),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_type     (evt_type),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d of %0d checks)", errors, checks);
    $fatal(1);
  end

  typedef struct {
    logic [3:0] keys;
    int         ticks;
    logic [3:0] exp_state;
    logic       exp_vld;
    logic [1:0] exp_key;
    logic [1:0] exp_type;
  } vec_t;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Wait (bounded) for a head event, compare it, then pop it with a one-cycle ready pulse.
  task automatic pop_evt(input string nm, input int idx, input logic [1:0] ek, input logic [1:0] et);
    int n;
    n = 0;
    while (!evt_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, idx, 32'(evt_valid), 32'd1);
    if (evt_valid) begin
      chk({nm, "_key"}, idx, 32'(evt_key), 32'(ek));
      chk({nm, "_type"}, idx, 32'(evt_type), 32'(et));
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
  endtask

  task automatic tap(input logic [3:0] k, input int hold, input int gap);
    key_in = k;
    repeat (hold * TD) @(negedge clk);
    key_in = 4'b0000;
    repeat (gap * TD) @(negedge clk);
  endtask

  vec_t       vt [16];
  logic [1:0] simul_exp [4];

  initial begin
    reset        = 1'b1;
    key_in       = 4'b0000;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 0, 32'(key_state), 32'd0);
    chk("rst_valid", 0, 32'(evt_valid), 32'd0);
    chk("rst_ovf",   0, 32'(overflow),  32'd0);
    reset = 1'b0;

    // Clean press/release of key 2, then a bounce on key 0 that must never commit.
    vt[0] = '{4'b0000, 2, 4'b0000, 1'b0, 2'd0, 2'b00};
    vt[1] = '{4'b0100, 6, 4'b0100, 1'b1, 2'd2, 2'b00};
    vt[2] = '{4'b0000, 6, 4'b0000, 1'b1, 2'd2, 2'b01};
    for (int i = 3; i < 13; i++)
      vt[i] = '{(i % 2 == 1) ? 4'b0001 : 4'b0000, 2, 4'b0000, 1'b0, 2'd0, 2'b00};
    vt[13] = '{4'b0000, 3, 4'b0000, 1'b0, 2'd0, 2'b00};
    vt[14] = '{4'b0001, 1, 4'b0000, 1'b0, 2'd0, 2'b00};
    vt[15] = '{4'b0000, 4, 4'b0000, 1'b0, 2'd0, 2'b00};
    for (int i = 0; i < 16; i++) begin
      key_in = vt[i].keys;
      repeat (vt[i].ticks * TD) @(negedge clk);
      chk("vec_state", i, 32'(key_state), 32'(vt[i].exp_state));
      chk("vec_valid", i, 32'(evt_valid), 32'(vt[i].exp_vld));
      if (vt[i].exp_vld && evt_valid) begin
        chk("vec_key",  i, 32'(evt_key),  32'(vt[i].exp_key));
        chk("vec_type", i, 32'(evt_type), 32'(vt[i].exp_type));
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
      end
    end
    chk("bounce_ovf", 0, 32'(overflow), 32'd0);

    // Long press on key 1: exactly press, long, release.
    key_in = 4'b0010;
    repeat (15 * TD) @(negedge clk);
    key_in = 4'b0000;
    repeat (6 * TD) @(negedge clk);
    pop_evt("long", 0, 2'd1, 2'b00);
    pop_evt("long", 1, 2'd1, 2'b10);
    pop_evt("long", 2, 2'd1, 2'b01);
    @(negedge clk);
    chk("long_only_one", 0, 32'(evt_valid), 32'd0);

    // All keys at once with rr_ptr at 2: keys 2,3,0,1 on consecutive cycles.
    simul_exp[0] = 2'd2; simul_exp[1] = 2'd3; simul_exp[2] = 2'd0; simul_exp[3] = 2'd1;
    evt_ready = 1'b1;
    key_in    = 4'b1111;
    for (int n = 0; n < 10 * TD && !evt_valid; n++) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      chk("simul_valid", j, 32'(evt_valid), 32'd1);
      chk("simul_key",   j, 32'(evt_key),   32'(simul_exp[j]));
      chk("simul_type",  j, 32'(evt_type),  32'(2'b00));
      @(negedge clk);
    end
    chk("simul_drained", 0, 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
    key_in    = 4'b0000;
    repeat (6 * TD) @(negedge clk);
    for (int j = 0; j < 4; j++) pop_evt("simul_rel", j, simul_exp[j], 2'b01);

    // Backpressure: six events, four queued and two held as flags.
    tap(4'b0001, 6, 6);
    tap(4'b0001, 6, 6);
    tap(4'b1000, 6, 6);
    chk("bp_ovf",   0, 32'(overflow),  32'd0);
    chk("bp_valid", 0, 32'(evt_valid), 32'd1);
    pop_evt("bp", 0, 2'd0, 2'b00);
    pop_evt("bp", 1, 2'd0, 2'b01);
    pop_evt("bp", 2, 2'd0, 2'b00);
    pop_evt("bp", 3, 2'd0, 2'b01);
    pop_evt("bp", 4, 2'd3, 2'b00);
    pop_evt("bp", 5, 2'd3, 2'b01);
    @(negedge clk);
    chk("bp_empty", 0, 32'(evt_valid), 32'd0);

    // Overflow: fill the FIFO, then press key 1 twice while its press flag is still held.
    tap(4'b0001, 6, 6);
    tap(4'b0001, 6, 6);
    tap(4'b0010, 6, 6);
    chk("ovf_before", 0, 32'(overflow), 32'd0);
    key_in = 4'b0010;
    repeat (6 * TD) @(negedge clk);
    chk("ovf_set", 0, 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_clr", 0, 32'(overflow), 32'd0);

    // Reset mid-SCAN with key 1 held through it.
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 0, 32'(evt_valid), 32'd0);
    chk("midrst_state", 0, 32'(key_state), 32'd0);
    chk("midrst_ovf",   0, 32'(overflow),  32'd0);
    reset = 1'b0;
    repeat (63) @(negedge clk);
    chk("held_pre_state", 0, 32'(key_state), 32'd0);
    chk("held_pre_valid", 0, 32'(evt_valid), 32'd0);
    @(negedge clk);
    chk("held_commit_state", 0, 32'(key_state), 32'(4'b0010));
    chk("held_commit_valid", 0, 32'(evt_valid), 32'd0);
    @(negedge clk);
    chk("held_evt_valid", 0, 32'(evt_valid), 32'd1);
    pop_evt("held", 0, 2'd1, 2'b00);
    key_in = 4'b0000;
    repeat (6 * TD) @(negedge clk);
    pop_evt("held", 1, 2'd1, 2'b01);
    @(negedge clk);
    chk("final_valid", 0, 32'(evt_valid), 32'd0);
    chk("final_ovf",   0, 32'(overflow),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
